early_out_div: RTL and testbench

Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU) sitting in the EX stage beside the ALU. It consumes the existing 32-bit leading-one encoder, instantiated internally on the dividend magnitude. The encoder returns the index of the most significant set bit, or 0 for inputs 0 and 1. The divider starts its restoring iteration at that bit, so latency scales with the dividend width rather than a fixed 32 cycles. Divide-by-zero, signed overflow and zero dividend finish on a fast path.

---
 rtl/early_out_div.sv | 207 ++++++++++++++++++++
 tb/tb_early_out_div.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/early_out_div.sv
// early_out_div: multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU).
//
// Restoring division, one quotient bit per cycle. Iteration starts at the
// leading-one position of the dividend magnitude, so small dividends finish
// early. Divide-by-zero, signed overflow and zero dividend take a fast path
// straight from INIT to DONE.
//
// Handshake: start is sampled only while idle (busy=0). When it is accepted,
// busy rises the next cycle and stays high until the cycle after the single
// valid pulse. result is written only on the edge that enters DONE, and it
// holds that value until the next valid. flush drops the operation in flight
// without producing valid or changing result.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   flush     kill the in-flight operation
//   start     request, sampled only in IDLE
//   op[1:0]   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  rs1, captured on accept
//   divisor   rs2, captured on accept
//   busy      high in every state except IDLE
//   valid     one-cycle pulse, result is final
//   result    quotient or remainder, held until the next valid

// Leading-one encoder: index of the most significant set bit (0 for 0 and 1).
module early_out_lead_one (
  input  logic [31:0] value,
  output logic [4:0]  index
);
  always_comb begin
    index = '0;
    for (int i = 1; i < 32; i++) begin
      if (value[i]) index = 5'(i);
    end
  end
endmodule

module early_out_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // state is kept as a named register so checkers can bind to it directly.
  state_t state;
  state_t state_next;

  logic [1:0]  op_q;
  logic [31:0] dvd_q;
  logic [31:0] dvs_q;
  logic [31:0] a_abs;
  logic [31:0] d_abs;
  logic [32:0] rem_r;
  logic [31:0] quo;
  logic [4:0]  cnt;

  // op[0]=0 selects the signed variants, op[1]=1 selects the remainder.
  logic is_signed;
  logic is_rem;
  logic a_neg;
  logic d_neg;
  logic [31:0] a_mag;
  logic [31:0] d_mag;
  logic [4:0]  lead_k;

  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];
  assign a_neg     = is_signed & dvd_q[31];
  assign d_neg     = is_signed & dvs_q[31];
  assign a_mag     = a_neg ? -dvd_q : dvd_q;
  assign d_mag     = d_neg ? -dvs_q : dvs_q;

  early_out_lead_one u_lead_one (
    .value (a_mag),
    .index (lead_k)
  );

  // Fast-path detection, evaluated on the latched operands during INIT.
  logic        fast_dz;
  logic        fast_ovf;
  logic        fast_zero;
  logic        fast;
  logic [31:0] fast_value;

  assign fast_dz   = (dvs_q == 32'd0);
  assign fast_ovf  = is_signed && (dvd_q == 32'h8000_0000) && (dvs_q == 32'hFFFF_FFFF);
  assign fast_zero = (dvd_q == 32'd0);
  assign fast      = fast_dz | fast_ovf | fast_zero;

  always_comb begin
    fast_value = 32'd0;
    if (fast_dz)       fast_value = is_rem ? dvd_q : 32'hFFFF_FFFF;
    else if (fast_ovf) fast_value = is_rem ? 32'd0 : 32'h8000_0000;
    else               fast_value = 32'd0;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder is always below |d|, so 33 bits cannot overflow.
  logic [32:0] r_shift;
  logic [32:0] r_sub;
  logic        take;

  assign r_shift = {rem_r[31:0], a_abs[cnt]};
  assign r_sub   = r_shift - {1'b0, d_abs};
  assign take    = (r_shift >= {1'b0, d_abs});

  // Sign fix-up: quotient negative when signs differ, remainder follows a.
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign q_fix = (a_neg ^ d_neg) ? -quo : quo;
  assign r_fix = a_neg ? -rem_r[31:0] : rem_r[31:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start && !flush) state_next = S_INIT;
      S_INIT: begin
        if (flush)     state_next = S_IDLE;
        else if (fast) state_next = S_DONE;
        else           state_next = S_ITER;
      end
      S_ITER: begin
        if (flush)           state_next = S_IDLE;
        else if (cnt == 5'd0) state_next = S_FIX;
      end
      S_FIX: begin
        if (flush) state_next = S_IDLE;
        else       state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy  = (state != S_IDLE);
    valid = (state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      a_abs  <= '0;
      d_abs  <= '0;
      rem_r  <= '0;
      quo    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            dvd_q <= dividend;
            dvs_q <= divisor;
          end
        end
        S_INIT: begin
          a_abs <= a_mag;
          d_abs <= d_mag;
          rem_r <= '0;
          quo   <= '0;
          cnt   <= lead_k;
          if (fast && !flush) result <= fast_value;
        end
        S_ITER: begin
          rem_r <= take ? r_sub : r_shift;
          if (take) quo[cnt] <= 1'b1;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        S_FIX: begin
          if (!flush) result <= is_rem ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_early_out_div.sv
module tb_early_out_div;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  early_out_div dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .valid    (valid),
    .result   (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          iss_q[$];
  logic [31:0] last_exp = 32'd0;
  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: RV32M semantics with plain arithmetic. Latency is
  // 2 for the fast cases, otherwise (msb index of |a|) + 4.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    logic [63:0] mag;
    sgn = (o == OP_DIV) || (o == OP_REM);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 2;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 2;
    end else if (a == 32'd0) begin
      q = 32'd0; r = 32'd0; lat = 2;
    end else begin
      if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        mag = a[31] ? 64'(-$signed(64'(signed'(a)))) : 64'(a);
      end else begin
        q = a / b;
        r = a % b;
        mag = 64'(a);
      end
      lat = $clog2(mag + 64'd1) + 3;
    end
    res = (o == OP_REM || o == OP_REMU) ? r : q;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_it);
    int guard;
    logic [31:0] res;
    int lat;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL idle_wait: busy stuck at %b expected 0 (cycle %0d)", busy, cyc);
    end
    start = 1'b1; op = o; dividend = a; divisor = b;
    if (expect_it) begin
      model(o, a, b, res, lat);
      exp_q.push_back(res);
      lat_q.push_back(lat);
      iss_q.push_back(cyc);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = $urandom();
      1: v = 32'($urandom_range(0, 15));
      2: case ($urandom_range(0, 4))
           0: v = 32'd0;
           1: v = 32'd1;
           2: v = 32'hFFFF_FFFF;
           3: v = 32'h8000_0000;
           default: v = 32'h7FFF_FFFF;
         endcase
      3: v = $urandom() >> $urandom_range(0, 31);
      4: v = -32'($urandom_range(1, 9));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e;
    int l;
    int s;
    forever begin
      @(negedge clk);
      if (!rst && valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid=1 result %h expected no valid (cycle %0d)", result, cyc);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          s = iss_q.pop_front();
          check("result", result, e);
          check("latency", 32'(cyc - s), 32'(l));
          last_exp = e;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = 2'b00;
    dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy",   {31'd0, busy},  32'd0);
    check("reset_valid",  {31'd0, valid}, 32'd0);
    check("reset_result", result,         32'd0);

    // Directed cases
    issue(OP_DIVU, 32'd100, 32'd7, 1);
    issue(OP_REMU, 32'd100, 32'd7, 1);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 1);
    issue(OP_DIV,  32'd7, 32'hFFFF_FFFE, 1);
    issue(OP_DIVU, 32'd5, 32'd0, 1);
    issue(OP_REMU, 32'd5, 32'd0, 1);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd0, 1);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(OP_DIVU, 32'd0, 32'd9, 1);

    // Worst case: busy must stay high for cycles 1..35, low in 36
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 1);
    for (int i = 1; i <= 35; i++) begin
      check($sformatf("worst_busy_c%0d", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("worst_busy_after", {31'd0, busy}, 32'd0);

    // start while busy is ignored
    issue(OP_DIVU, 32'd100, 32'd7, 1);
    start = 1'b1; op = OP_DIV; dividend = 32'd1000; divisor = 32'd3;
    repeat (3) @(negedge clk);
    start = 1'b0;

    // flush in cycle 5 of DIVU 100/7
    issue(OP_DIVU, 32'd100, 32'd7, 0);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy",   {31'd0, busy}, 32'd0);
    check("flush_result", result,        last_exp);
    for (int i = 0; i < 12; i++) begin
      check("flush_no_valid", {31'd0, valid}, 32'd0);
      @(negedge clk);
    end

    // reset mid-ITER, then a fresh operation
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_valid",  {31'd0, valid}, 32'd0);
    check("rst_result", result,         32'd0);
    issue(OP_DIVU, 32'd9, 32'd3, 1);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      issue(ro, ra, rb, 1);
    end

    // Drain
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
